// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 add/multiply sequencer: state encoding,
// exponent constants, field layout and the unpacked-operand view.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5,
        ST_NORM   = 3'd6,
        ST_PACK   = 3'd7
    } state_e;

    localparam logic signed [9:0] BIAS       = 10'sd127;
    localparam logic signed [9:0] EXP_MAX    = 10'sd255;
    localparam logic [31:0]       QNAN_CANON = 32'h7FC0_0000;

    localparam int SIGN_POS = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_unp_t;

    // Denormals are flushed: a zero exponent always reads as zero.
    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.sign    = x[SIGN_POS];
        u.exp     = x[EXP_MSB:EXP_LSB];
        u.is_zero = (u.exp == 8'd0);
        u.is_inf  = (u.exp == 8'hFF) && (x[FRAC_MSB:0] == 23'd0);
        u.is_nan  = (u.exp == 8'hFF) && (x[FRAC_MSB:0] != 23'd0);
        u.mant    = u.is_zero ? 24'd0 : {1'b1, x[FRAC_MSB:0]};
        return u;
    endfunction

    function automatic logic [31:0] fp_pack(input logic s, input logic [7:0] e,
                                            input logic [23:0] m);
        return {s, e, m[FRAC_MSB:0]};
    endfunction

endpackage

// File: rtl/fpu_sequenciador_if.sv
// Issue-side handshake plus mantissa ULA port of the sequencer in one bundle.
interface fpu_sequenciador_if;
    logic        op_valid;
    logic        op_mult;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        res_valid;
    logic [31:0] result;
    logic        erro;
    logic [23:0] ula_a;
    logic [23:0] ula_b;
    logic        ula_mult;
    logic        ula_start;
    logic [27:0] ula_dout;
    logic        ula_finish;

    modport master (
        output op_valid, op_mult, op_a, op_b, ula_dout, ula_finish,
        input  op_ready, res_valid, result, erro, ula_a, ula_b, ula_mult, ula_start
    );

    modport slave (
        input  op_valid, op_mult, op_a, op_b, ula_dout, ula_finish,
        output op_ready, res_valid, result, erro, ula_a, ula_b, ula_mult, ula_start
    );
endinterface

// File: rtl/fpu_normaliza.sv
// Leading-zero count and left shift that brings bit 23 of a 24-bit mantissa to one.
module fpu_normaliza (
    input  logic [23:0] mant_i,
    output logic [23:0] mant_o,
    output logic [4:0]  lz_o,
    output logic        zero_o
);

    // Highest set bit wins because the scan runs from the LSB upwards.
    always_comb begin
        lz_o = 5'd0;
        for (int i = 0; i < 24; i++) begin
            lz_o = mant_i[i] ? 5'(23 - i) : lz_o;
        end
    end

    assign mant_o = mant_i << lz_o;
    assign zero_o = (mant_i == 24'd0);

endmodule

// File: rtl/fpu_sequenciador.sv
// Sequences one binary32 add or multiply through the shared mantissa ULA,
// with special-operand bypass, truncating normalisation and a ULA watchdog.
module fpu_sequenciador
    import fpu_pkg::*;
#(
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] NAN_CANON = QNAN_CANON
) (
    input logic                clk,
    input logic                reset,
    fpu_sequenciador_if.slave  bus
);

    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              mult_q, mult_d, sub_q, sub_d, sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       ma_q, ma_d, mb_q, mb_d;
    logic [27:0]       dout_q, dout_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       pk_s;
    logic              err_s;

    logic              ready_q, ready_d, rvalid_q, rvalid_d, erro_q, erro_d;
    logic [31:0]       result_q, result_d;
    logic [23:0]       ula_a_q, ula_a_d, ula_b_q, ula_b_d;
    logic              ula_mult_q, ula_mult_d, ula_start_q, ula_start_d;

    fp_unp_t           ua_s, ub_s;
    logic              a_ge_s, nan_s, inf_sign_s;
    logic              big_sign_s, sml_sign_s;
    logic [7:0]        big_exp_s, sml_exp_s, dexp_s;
    logic [23:0]       big_mant_s, sml_mant_s, mb_sh_s;
    logic [23:0]       nz_mant_s, nm_s;
    logic [4:0]        nz_lz_s;
    logic              nz_zero_s;
    logic signed [9:0] ne_s;
    logic              unused_ok_s;

    assign ua_s       = fp_unpack(a_q);
    assign ub_s       = fp_unpack(b_q);
    assign a_ge_s     = {ua_s.exp, ua_s.mant} >= {ub_s.exp, ub_s.mant};
    assign big_sign_s = a_ge_s ? ua_s.sign : ub_s.sign;
    assign sml_sign_s = a_ge_s ? ub_s.sign : ua_s.sign;
    assign big_exp_s  = a_ge_s ? ua_s.exp  : ub_s.exp;
    assign sml_exp_s  = a_ge_s ? ub_s.exp  : ua_s.exp;
    assign big_mant_s = a_ge_s ? ua_s.mant : ub_s.mant;
    assign sml_mant_s = a_ge_s ? ub_s.mant : ua_s.mant;
    assign dexp_s     = big_exp_s - sml_exp_s;
    assign mb_sh_s    = sml_mant_s >> dexp_s;
    assign nan_s      = ua_s.is_nan | ub_s.is_nan
                      | (mult_q & ((ua_s.is_inf & ub_s.is_zero) | (ub_s.is_inf & ua_s.is_zero)))
                      | (~mult_q & ua_s.is_inf & ub_s.is_inf & (ua_s.sign ^ ub_s.sign));
    assign inf_sign_s = mult_q ? (ua_s.sign ^ ub_s.sign) : (ua_s.is_inf ? ua_s.sign : ub_s.sign);
    // Rounding is truncation, so the guard bits below the sum are dropped.
    assign unused_ok_s = ^dout_q[2:0];

    fpu_normaliza u_normaliza (
        .mant_i (ma_q),
        .mant_o (nz_mant_s),
        .lz_o   (nz_lz_s),
        .zero_o (nz_zero_s)
    );

    // Normalised mantissa/exponent: add and multiply share the bit-27 carry test.
    always_comb begin
        if (sub_q) begin
            nm_s = nz_mant_s;
            ne_s = exp_q - $signed({5'd0, nz_lz_s});
        end else if (dout_q[27]) begin
            nm_s = dout_q[27:4];
            ne_s = exp_q + 10'sd1;
        end else begin
            nm_s = dout_q[26:3];
            ne_s = exp_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mult_d  = mult_q;
        sub_d   = sub_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        dout_d  = dout_q;
        wd_d    = wd_q;
        pk_s    = NAN_CANON;
        err_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    mult_d  = bus.op_mult;
                    state_d = ST_UNPACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                if (nan_s) begin
                    pk_s    = NAN_CANON;
                    state_d = ST_PACK;
                end else if (ua_s.is_inf || ub_s.is_inf) begin
                    pk_s    = {inf_sign_s, 8'hFF, 23'd0};
                    state_d = ST_PACK;
                end else if (ua_s.is_zero || ub_s.is_zero) begin
                    pk_s    = mult_q ? {ua_s.sign ^ ub_s.sign, 31'd0} : (ua_s.is_zero ? b_q : a_q);
                    state_d = ST_PACK;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (mult_q) begin
                    sign_d  = ua_s.sign ^ ub_s.sign;
                    exp_d   = $signed({2'b00, ua_s.exp}) + $signed({2'b00, ub_s.exp}) - BIAS;
                    ma_d    = ua_s.mant;
                    mb_d    = ub_s.mant;
                    sub_d   = 1'b0;
                    state_d = ST_ISSUE;
                end else if (dexp_s >= 8'd25) begin
                    pk_s    = a_ge_s ? a_q : b_q;
                    state_d = ST_PACK;
                end else begin
                    sign_d = big_sign_s;
                    exp_d  = $signed({2'b00, big_exp_s});
                    mb_d   = mb_sh_s;
                    if (big_sign_s != sml_sign_s) begin
                        ma_d    = big_mant_s - mb_sh_s;
                        sub_d   = 1'b1;
                        state_d = ST_NORM;
                    end else begin
                        ma_d    = big_mant_s;
                        sub_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.ula_finish) begin
                    dout_d  = bus.ula_dout;
                    state_d = ST_GAP;
                end else if (wd_q == WD_LAST) begin
                    pk_s    = NAN_CANON;
                    err_s   = 1'b1;
                    state_d = ST_PACK;
                end else begin
                    wd_d    = wd_q + WD_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (sub_q && nz_zero_s) begin
                    pk_s = 32'd0;
                end else if (ne_s >= EXP_MAX) begin
                    pk_s = {sign_q, 8'hFF, 23'd0};
                end else if (ne_s <= 10'sd0) begin
                    pk_s = {sign_q, 31'd0};
                end else begin
                    pk_s = fp_pack(sign_q, ne_s[7:0], nm_s);
                end
                state_d = ST_PACK;
            end
            ST_PACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        rvalid_d    = (state_d == ST_PACK);
        result_d    = (state_d == ST_PACK) ? pk_s  : result_q;
        erro_d      = (state_d == ST_PACK) ? err_s : erro_q;
        ula_start_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        ula_a_d     = (state_d == ST_ISSUE) ? ma_d   : ula_a_q;
        ula_b_d     = (state_d == ST_ISSUE) ? mb_d   : ula_b_q;
        ula_mult_d  = (state_d == ST_ISSUE) ? mult_q : ula_mult_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            mult_q      <= 1'b0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            ma_q        <= 24'd0;
            mb_q        <= 24'd0;
            dout_q      <= 28'd0;
            wd_q        <= '0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            result_q    <= 32'd0;
            erro_q      <= 1'b0;
            ula_start_q <= 1'b0;
            ula_a_q     <= 24'd0;
            ula_b_q     <= 24'd0;
            ula_mult_q  <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            mult_q      <= mult_d;
            sub_q       <= sub_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            dout_q      <= dout_d;
            wd_q        <= wd_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            result_q    <= result_d;
            erro_q      <= erro_d;
            ula_start_q <= ula_start_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_mult_q  <= ula_mult_d;
        end
    end

    assign bus.op_ready  = ready_q;
    assign bus.res_valid = rvalid_q;
    assign bus.result    = result_q;
    assign bus.erro      = erro_q;
    assign bus.ula_start = ula_start_q;
    assign bus.ula_a     = ula_a_q;
    assign bus.ula_b     = ula_b_q;
    assign bus.ula_mult  = ula_mult_q;

endmodule

// File: tb/tb_fpu_sequenciador.sv
// Directed bench for fpu_sequenciador with a behavioural 3-cycle mantissa ULA.
module tb_fpu_sequenciador;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    logic hang;
    always #5 clk = ~clk;

    fpu_sequenciador_if bus ();

    fpu_sequenciador #(
        .TIMEOUT   (TIMEOUT),
        .NAN_CANON (32'h7FC0_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ULA model: sum aligned at [27:3], product binary point between bits 26 and 25.
    logic [47:0] prod_s;
    logic [24:0] sum_s;
    logic [1:0]  ula_cnt = 2'd0;
    assign prod_s       = bus.ula_a * bus.ula_b;
    assign sum_s        = {1'b0, bus.ula_a} + {1'b0, bus.ula_b};
    assign bus.ula_dout = bus.ula_mult ? prod_s[47:20] : {sum_s, 3'b000};

    always @(posedge clk) begin
        if (bus.ula_start !== 1'b1 || hang) begin
            ula_cnt        <= 2'd0;
            bus.ula_finish <= 1'b0;
        end else if (ula_cnt == 2'd2) begin
            bus.ula_finish <= 1'b1;
        end else begin
            ula_cnt <= ula_cnt + 2'd1;
        end
    end

    int   n_rise = 0, n_start_hi = 0, n_start_mult = 0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.ula_start === 1'b1 && start_prev !== 1'b1) n_rise <= n_rise + 1;
        if (bus.ula_start === 1'b1) n_start_hi <= n_start_hi + 1;
        if (bus.ula_start === 1'b1 && bus.ula_mult === 1'b1) n_start_mult <= n_start_mult + 1;
        start_prev <= bus.ula_start;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic mult, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                          output int lat, output int rises);
        int r0;
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, bus.op_ready}, 32'd1);
        r0           = n_rise;
        bus.op_valid = 1'b1;
        bus.op_mult  = mult;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        n = 1;
        while (bus.res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat   = n;
        rises = n_rise - r0;
        chk({tag, "_done"}, {31'd0, bus.res_valid}, 32'd1);
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_erro"}, {31'd0, bus.erro}, {31'd0, exp_err});
    endtask

    initial begin
        int lat, rises, hi0, m0, nrv;
        reset        = 1'b1;
        hang         = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_mult  = 1'b0;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_erro", {31'd0, bus.erro}, 32'd0);
        chk("rst_start", {31'd0, bus.ula_start}, 32'd0);
        chk("rst_ula_a", {8'd0, bus.ula_a}, 32'd0);
        chk("rst_ula_b", {8'd0, bus.ula_b}, 32'd0);
        chk("rst_ula_mult", {31'd0, bus.ula_mult}, 32'd0);
        reset = 1'b0;

        // ULA path: accept, UNPACK, ALIGN, ISSUE, 3 ULA cycles, GAP, NORM, PACK.
        run_op("add_1p1", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, lat, rises);
        chk("add_1p1_lat", lat, 32'd9);
        chk("add_1p1_rises", rises, 32'd1);

        hi0 = n_start_hi;
        m0  = n_start_mult;
        run_op("mul_1p5x2", 1'b1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, lat, rises);
        chk("mul_1p5x2_rises", rises, 32'd1);
        chk("mul_1p5x2_start_hi", n_start_hi - hi0, 32'd4);
        chk("mul_1p5x2_mult_hi", n_start_mult - m0, 32'd4);

        run_op("add_1m1", 1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, lat, rises);
        chk("add_1m1_rises", rises, 32'd0);
        chk("add_1m1_fast", {31'd0, lat <= 5}, 32'd1);
        run_op("add_3m1", 1'b0, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, lat, rises);
        chk("add_3m1_rises", rises, 32'd0);
        run_op("add_1m3", 1'b0, 32'h3F80_0000, 32'hC040_0000, 32'hC000_0000, 1'b0, lat, rises);
        run_op("add_1p5p1", 1'b0, 32'h3FC0_0000, 32'h3F80_0000, 32'h4020_0000, 1'b0, lat, rises);
        run_op("add_neg", 1'b0, 32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000, 1'b0, lat, rises);
        run_op("mul_1p5sq", 1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, lat, rises);

        run_op("nan_mul", 1'b1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, lat, rises);
        chk("nan_mul_lat", lat, 32'd2);
        run_op("inf_minf", 1'b0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, lat, rises);
        run_op("mul_ovf", 1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0, lat, rises);
        run_op("mul_unf", 1'b1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, lat, rises);
        run_op("mul_zero", 1'b1, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, lat, rises);
        chk("mul_zero_rises", rises, 32'd0);
        run_op("add_zero", 1'b0, 32'h0000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, lat, rises);
        run_op("add_far", 1'b0, 32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 1'b0, lat, rises);
        chk("add_far_rises", rises, 32'd0);
        chk("add_far_fast", {31'd0, lat <= 5}, 32'd1);

        // ISSUE is cycle 3, the watchdog expires TIMEOUT cycles later, PACK follows.
        hang = 1'b1;
        run_op("tmo", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, lat, rises);
        chk("tmo_lat", lat, TIMEOUT + 4);
        chk("tmo_start_low", {31'd0, bus.ula_start}, 32'd0);
        chk("tmo_rises", rises, 32'd1);
        hang = 1'b0;
        run_op("after_tmo", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, lat, rises);

        hang = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_mult  = 1'b0;
        bus.op_a     = 32'h3F80_0000;
        bus.op_b     = 32'h3F80_0000;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw_pre_start", {31'd0, bus.ula_start}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_start", {31'd0, bus.ula_start}, 32'd0);
        chk("rstw_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("rstw_rvalid", {31'd0, bus.res_valid}, 32'd0);
        reset = 1'b0;
        hang  = 1'b0;
        nrv   = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) nrv++;
        end
        chk("rstw_no_result", nrv, 32'd0);

        run_op("b2b_mul", 1'b1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, lat, rises);
        chk("b2b_mul_rises", rises, 32'd1);
        run_op("b2b_add", 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, lat, rises);
        chk("b2b_add_rises", rises, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
